product_bcd_display: RTL and testbench

Downstream consumer of the 8x8 multiplier's 16-bit result. Captures product8_8 on the rising edge of done_flag and converts it to 5-digit BCD with a sequential double-dabble (one iteration per clock). Drives a time-multiplexed 5-digit 7-segment display (digit enables plus shared seg_a..seg_g) from the latched BCD value.

---
 rtl/product_bcd_display.sv | 217 +++++++++++++++++++++
 tb/tb_product_bcd_display.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/product_bcd_display.sv
// Captures the multiplier product, converts it to 5-digit BCD with sequential double-dabble, and scans a 5-digit 7-segment display.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits above the units.
module product_bcd_display #(
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter int unsigned SEG_ACTIVE_LOW = 0
) (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        done_flag,
  input  logic [15:0] product8_8,
  output logic        busy,
  output logic        bcd_valid,
  output logic [19:0] bcd,
  output logic [4:0]  digit_en,
  output logic        seg_a,
  output logic        seg_b,
  output logic        seg_c,
  output logic        seg_d,
  output logic        seg_e,
  output logic        seg_f,
  output logic        seg_g
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic        INV   = (SEG_ACTIVE_LOW != 0);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] DISPLAY = 2'd2;

  logic [1:0]       state_q, state_nx;
  logic             done_d_q, done_d_nx;
  logic [15:0]      shift_q, shift_nx;
  logic [19:0]      scratch_q, scratch_nx;
  logic [3:0]       iter_q, iter_nx;
  logic             busy_q, busy_nx;
  logic             valid_q, valid_nx;
  logic [19:0]      bcd_q, bcd_nx;
  logic             has_result_q, has_result_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [2:0]       idx_q, idx_nx;
  logic [4:0]       en_q, en_nx;
  logic [6:0]       seg_q, seg_nx;

  logic        start;
  logic        scan_on;
  logic        lz_blank;
  logic [3:0]  nib;
  logic [19:0] adj;
  logic [19:0] scratch_sh;
  logic [15:0] shift_sh;

  // Segment pattern {a,b,c,d,e,f,g}; non-decimal nibbles are blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  function automatic logic [3:0] pick(input logic [19:0] v, input logic [2:0] i);
    case (i)
      3'd0:    pick = v[3:0];
      3'd1:    pick = v[7:4];
      3'd2:    pick = v[11:8];
      3'd3:    pick = v[15:12];
      3'd4:    pick = v[19:16];
      default: pick = 4'd0;
    endcase
  endfunction

  assign start   = done_flag & ~done_d_q;
  assign scan_on = (state_q == DISPLAY) || ((state_q == CONVERT) && has_result_q);
  assign nib     = pick(bcd_q, idx_q);

  // One double-dabble step: add-3 correction, then shift {scratch,shift} left.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 5; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    scratch_sh = 20'({adj, shift_q[15]});
    shift_sh   = {shift_q[14:0], 1'b0};
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_blank = 1'b0;
    case (idx_q)
      3'd1:    lz_blank = (bcd_q[19:4]  == 16'd0);
      3'd2:    lz_blank = (bcd_q[19:8]  == 12'd0);
      3'd3:    lz_blank = (bcd_q[19:12] == 8'd0);
      3'd4:    lz_blank = (bcd_q[19:16] == 4'd0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_nx      = state_q;
    done_d_nx     = done_flag;
    shift_nx      = shift_q;
    scratch_nx    = scratch_q;
    iter_nx       = iter_q;
    busy_nx       = busy_q;
    valid_nx      = valid_q;
    bcd_nx        = bcd_q;
    has_result_nx = has_result_q;
    cnt_nx        = cnt_q;
    idx_nx        = idx_q;
    en_nx         = en_q;
    seg_nx        = seg_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_nx   = product8_8;
          scratch_nx = 20'd0;
          iter_nx    = 4'd0;
          busy_nx    = 1'b1;
          state_nx   = CONVERT;
        end
      end
      CONVERT: begin
        scratch_nx = scratch_sh;
        shift_nx   = shift_sh;
        iter_nx    = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          bcd_nx        = scratch_sh;
          valid_nx      = 1'b1;
          busy_nx       = 1'b0;
          has_result_nx = 1'b1;
          state_nx      = DISPLAY;
        end
      end
      DISPLAY: begin
        if (start) begin
          shift_nx   = product8_8;
          scratch_nx = 20'd0;
          iter_nx    = 4'd0;
          busy_nx    = 1'b1;
          valid_nx   = 1'b0;
          state_nx   = CONVERT;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Digit enable and segments are registered together from the same index.
    if (scan_on) begin
      en_nx  = 5'(1) << idx_q;
      seg_nx = lz_blank ? 7'd0 : seg7(nib);
      if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
        cnt_nx = '0;
        idx_nx = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
      end else begin
        cnt_nx = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_nx = '0;
      idx_nx = 3'd0;
      en_nx  = 5'd0;
      seg_nx = 7'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_a) begin
      state_q      <= IDLE;
      done_d_q     <= 1'b0;
      shift_q      <= 16'd0;
      scratch_q    <= 20'd0;
      iter_q       <= 4'd0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      bcd_q        <= 20'd0;
      has_result_q <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      en_q         <= 5'd0;
      seg_q        <= 7'd0;
    end else begin
      state_q      <= state_nx;
      done_d_q     <= done_d_nx;
      shift_q      <= shift_nx;
      scratch_q    <= scratch_nx;
      iter_q       <= iter_nx;
      busy_q       <= busy_nx;
      valid_q      <= valid_nx;
      bcd_q        <= bcd_nx;
      has_result_q <= has_result_nx;
      cnt_q        <= cnt_nx;
      idx_q        <= idx_nx;
      en_q         <= en_nx;
      seg_q        <= seg_nx;
    end
  end

  assign busy      = busy_q;
  assign bcd_valid = valid_q;
  assign bcd       = bcd_q;
  assign digit_en  = en_q ^ {5{INV}};
  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg_q ^ {7{INV}};

endmodule

// File: tb/tb_product_bcd_display.sv
// Self-checking bench for product_bcd_display: table vectors, random products, and multi-cycle corner cases.
module tb_product_bcd_display;

  localparam int unsigned DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk;
  logic        reset_a;
  logic        done_flag;
  logic [15:0] product8_8;

  logic        busy, bcd_valid;
  logic [19:0] bcd;
  logic [4:0]  digit_en;
  logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  logic [6:0]  segs;

  logic        l_busy, l_bcd_valid;
  logic [19:0] l_bcd;
  logic [4:0]  l_digit_en;
  logic        l_seg_a, l_seg_b, l_seg_c, l_seg_d, l_seg_e, l_seg_f, l_seg_g;
  logic [6:0]  l_segs;

  int          checks;
  int          errors;
  logic [19:0] cur_bcd;
  bit          have_result;

  typedef struct {
    logic [15:0] prod;
    logic [19:0] exp;
  } vec_t;
  vec_t vecs [7];

  assign segs   = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
  assign l_segs = {l_seg_a, l_seg_b, l_seg_c, l_seg_d, l_seg_e, l_seg_f, l_seg_g};

  product_bcd_display #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(0)) dut (
    .clk(clk), .reset_a(reset_a), .done_flag(done_flag), .product8_8(product8_8),
    .busy(busy), .bcd_valid(bcd_valid), .bcd(bcd), .digit_en(digit_en),
    .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
    .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g)
  );

  product_bcd_display #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1)) dut_low (
    .clk(clk), .reset_a(reset_a), .done_flag(done_flag), .product8_8(product8_8),
    .busy(l_busy), .bcd_valid(l_bcd_valid), .bcd(l_bcd), .digit_en(l_digit_en),
    .seg_a(l_seg_a), .seg_b(l_seg_b), .seg_c(l_seg_c), .seg_d(l_seg_d),
    .seg_e(l_seg_e), .seg_f(l_seg_f), .seg_g(l_seg_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by plain division.
  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int          x;
    r = 20'd0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] ref_seg(input int d);
    logic [6:0] tab [10];
    tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    return (d >= 0 && d < 10) ? tab[d] : 7'd0;
  endfunction

  function automatic logic [6:0] ref_disp(input logic [19:0] v, input int k);
    if (LZB && k > 0 && (v >> (4*k)) == 20'd0) return 7'd0;
    return ref_seg(int'(v[4*k +: 4]));
  endfunction

  // Pulse a start, optionally re-pulse done_flag mid-conversion, and check latency/result.
  task automatic run_conv(input logic [15:0] p, input logic [19:0] exp, input int glitch_at);
    int lat;
    lat = 0;
    @(negedge clk);
    done_flag  = 1'b1;
    product8_8 = p;
    @(negedge clk);
    done_flag = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_valid_low", 32'(bcd_valid), 32'd0);
    chk("persist_bcd", 32'(bcd), 32'(cur_bcd));
    if (have_result) chk("persist_scan", 32'(digit_en != 5'd0), 32'd1);
    else             chk("blank_scan", 32'(digit_en), 32'd0);
    product8_8 = 16'($urandom);
    for (int m = 1; m <= 40; m++) begin
      @(negedge clk);
      if (bcd_valid) begin
        lat = m;
        break;
      end
      done_flag = (m == glitch_at);
    end
    done_flag = 1'b0;
    chk("latency", 32'(lat), 32'd16);
    chk("bcd", 32'(bcd), 32'(exp));
    chk("bcd_inv_inst", 32'(l_bcd), 32'(exp));
    chk("busy_end", 32'(busy), 32'd0);
    cur_bcd     = exp;
    have_result = 1'b1;
  endtask

  // Scan: one-hot enable, segments match its digit, rotation order and dwell time.
  task automatic check_scan(input logic [19:0] v, input int n);
    logic [4:0] prev;
    int run, changes, k;
    repeat (2) @(negedge clk);
    prev    = digit_en;
    run     = 0;
    changes = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      chk("scan_onehot", 32'($onehot(digit_en)), 32'd1);
      k = 0;
      for (int j = 0; j < 5; j++) if (digit_en[j]) k = j;
      chk("scan_seg", 32'(segs), 32'(ref_disp(v, k)));
      if (digit_en == prev) begin
        run++;
      end else begin
        if (changes > 0) chk("scan_dwell", 32'(run), 32'(DIV));
        chk("scan_order", 32'(digit_en), 32'({prev[3:0], prev[4]}));
        changes++;
        run  = 1;
        prev = digit_en;
      end
    end
    chk("scan_moves", 32'(changes > 1), 32'd1);
  endtask

  initial begin
    int   rises;
    logic prevv;
    bit   found;
    logic [15:0] rp;

    checks      = 0;
    errors      = 0;
    cur_bcd     = 20'd0;
    have_result = 1'b0;
    reset_a     = 1'b0;
    done_flag   = 1'b0;
    product8_8  = 16'd0;

    vecs[0] = '{16'd500,   20'h00500};
    vecs[1] = '{16'd50,    20'h00050};
    vecs[2] = '{16'd1280,  20'h01280};
    vecs[3] = '{16'd65535, 20'h65535};
    vecs[4] = '{16'd0,     20'h00000};
    vecs[5] = '{16'd9999,  20'h09999};
    vecs[6] = '{16'd10,    20'h00010};

    repeat (2) @(negedge clk);
    reset_a = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(bcd_valid), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_en", 32'(digit_en), 32'd0);
    chk("rst_seg", 32'(segs), 32'd0);
    chk("rst_inv_en", 32'(l_digit_en), 32'h1f);
    chk("rst_inv_seg", 32'(l_segs), 32'h7f);
    chk("rst_inv_busy", 32'({l_busy, l_bcd_valid}), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_conv(vecs[i].prod, vecs[i].exp, 0);
      check_scan(vecs[i].exp, 24);
    end

    // done_flag held high: a single conversion.
    @(negedge clk);
    product8_8 = 16'd1280;
    done_flag  = 1'b1;
    rises      = 0;
    prevv      = bcd_valid;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bcd_valid && !prevv) rises++;
      prevv = bcd_valid;
    end
    done_flag = 1'b0;
    chk("held_rises", 32'(rises), 32'd1);
    chk("held_bcd", 32'(bcd), 32'h01280);
    cur_bcd = 20'h01280;

    // A start during CONVERT is ignored.
    run_conv(16'd1280, 20'h01280, 5);

    // Reset at iteration 8 discards the conversion.
    @(negedge clk);
    done_flag  = 1'b1;
    product8_8 = 16'd500;
    @(negedge clk);
    done_flag = 1'b0;
    repeat (8) @(negedge clk);
    reset_a = 1'b0;
    @(negedge clk);
    reset_a = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(bcd_valid), 32'd0);
    chk("mid_rst_bcd", 32'(bcd), 32'd0);
    chk("mid_rst_en", 32'(digit_en), 32'd0);
    chk("mid_rst_seg", 32'(segs), 32'd0);
    chk("mid_rst_inv", 32'({l_digit_en, l_segs}), 32'hfff);
    have_result = 1'b0;
    cur_bcd     = 20'd0;
    run_conv(16'd1280, 20'h01280, 0);
    check_scan(20'h01280, 24);

    for (int i = 0; i < 15; i++) begin
      rp = 16'($urandom_range(0, 65535));
      run_conv(rp, ref_bcd(int'(rp)), (i % 3 == 0) ? 7 : 0);
      if (i % 4 == 0) check_scan(ref_bcd(int'(rp)), 16);
    end

    // Active-low instance: an "8" on the units digit drives every segment low.
    run_conv(16'd8, 20'h00008, 0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (l_digit_en == 5'b11110) begin
        found = 1'b1;
        chk("inv_units_seg", 32'(l_segs), 32'd0);
        chk("inv_units_hi_en", 32'(digit_en), 32'd1);
        chk("inv_units_hi_seg", 32'(segs), 32'h7f);
      end
    end
    chk("inv_units_found", 32'(found), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
